// File: rtl/trainer_truth_table_sequencer.sv
// ----------------------------------------------------------------------------
// trainer_truth_table_sequencer
//
// Stimulus stage for the trainer's logic-gate unit. A start request latches
// a gate select and then drives the four {a,b} input vectors in order. After
// each vector is applied, the block waits SETTLE_CYCLES cycles and then
// samples the gate output y. The four samples form a truth table, which is
// compared with the expected table for the latched gate.
//
// Parameters
//   SETTLE_CYCLES : wait cycles between applying a vector and sampling y.
//                   Legal range is 1..255 (8-bit counter).
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ena         in   block enable; low forces a synchronous abort to IDLE
//   start       in   run request, sampled only in IDLE with ena=1
//   sel_in      in   gate select [2:0], latched at start
//   y_in        in   gate-unit output
//   a_out       out  operand a
//   b_out       out  operand b
//   sel_out     out  latched gate select [2:0]
//   busy        out  high while a run is in progress
//   done        out  one-cycle pulse at run completion
//   table_valid out  high from done until the next start, abort or reset
//   table_out   out  captured truth table [3:0], bit index = {a,b}
//   pass        out  table_out matches the expected table (0 for sel 111)
// ----------------------------------------------------------------------------
module trainer_truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [2:0] sel_in,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic [2:0] sel_out,
    output logic       busy,
    output logic       done,
    output logic       table_valid,
    output logic [3:0] table_out,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic       a_d, b_d;
    logic [2:0] sel_d;
    logic       busy_d, done_d, valid_d, pass_d;
    logic [3:0] table_d;
    logic [3:0] exp_table;

    // Reference table for the latched select; the reserved code 111 maps to
    // all zeros and has pass forced low separately.
    always_comb begin
        unique case (sel_out)
            3'b000:  exp_table = 4'b1000;  // AND
            3'b001:  exp_table = 4'b1110;  // OR
            3'b010:  exp_table = 4'b0111;  // NAND
            3'b011:  exp_table = 4'b0001;  // NOR
            3'b100:  exp_table = 4'b0110;  // XOR
            3'b101:  exp_table = 4'b1001;  // XNOR
            3'b110:  exp_table = 4'b0011;  // NOT a
            default: exp_table = 4'b0000;  // reserved
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case below leaves one unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        a_d     = a_out;
        b_d     = b_out;
        sel_d   = sel_out;
        busy_d  = busy;
        done_d  = 1'b0;           // done is a single-cycle pulse
        valid_d = table_valid;
        pass_d  = pass;
        table_d = table_out;

        if (!ena) begin
            // Abort: clear everything except the latched select.
            state_d = IDLE;
            cnt_d   = 8'd0;
            idx_d   = 2'd0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            pass_d  = 1'b0;
            table_d = 4'b0000;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SETTLE;
                        sel_d   = sel_in;
                        idx_d   = 2'd0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        cnt_d   = CNT_RELOAD;
                        busy_d  = 1'b1;
                        valid_d = 1'b0;
                        pass_d  = 1'b0;
                        table_d = 4'b0000;
                    end
                end

                SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end

                SAMPLE: begin
                    table_d[idx_q] = y_in;
                    if (idx_q == 2'd3) begin
                        // Results are registered on the final sampling edge
                        // so they are visible during the DONE cycle.
                        state_d = DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        pass_d  = (table_d == exp_table) && (sel_out != 3'b111);
                    end else begin
                        idx_d        = idx_q + 2'd1;
                        {a_d, b_d}   = idx_q + 2'd1;
                        cnt_d        = CNT_RELOAD;
                        state_d      = SETTLE;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values that existed before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            idx_q       <= 2'd0;
            a_out       <= 1'b0;
            b_out       <= 1'b0;
            sel_out     <= 3'b000;
            busy        <= 1'b0;
            done        <= 1'b0;
            table_valid <= 1'b0;
            table_out   <= 4'b0000;
            pass        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            a_out       <= a_d;
            b_out       <= b_d;
            sel_out     <= sel_d;
            busy        <= busy_d;
            done        <= done_d;
            table_valid <= valid_d;
            table_out   <= table_d;
            pass        <= pass_d;
        end
    end

endmodule

// File: tb/tb_trainer_truth_table_sequencer.sv
// ----------------------------------------------------------------------------
// Testbench for trainer_truth_table_sequencer.
// Two instances share the clock and reset: dut0 uses SETTLE_CYCLES=4 and
// dut1 uses SETTLE_CYCLES=1. Each gate unit is modelled as a 4-entry lookup
// table indexed by the driven {a,b}. The table is either the ideal gate
// response or a faulty/random one. Expected results come from a gate-level
// reference function and from constant tables.
// ----------------------------------------------------------------------------
module tb_trainer_truth_table_sequencer;

    localparam int S0 = 4;
    localparam int S1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut0 signals
    logic       ena0, start0, y0, a0, b0, busy0, done0, tv0, pass0;
    logic [2:0] sel0, selo0;
    logic [3:0] to0, tbl0;
    // dut1 signals
    logic       ena1, start1, y1, a1, b1, busy1, done1, tv1, pass1;
    logic [2:0] sel1, selo1;
    logic [3:0] to1, tbl1;

    assign y0 = tbl0[{a0, b0}];
    assign y1 = tbl1[{a1, b1}];

    trainer_truth_table_sequencer #(.SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena0), .start(start0), .sel_in(sel0),
        .y_in(y0), .a_out(a0), .b_out(b0), .sel_out(selo0), .busy(busy0),
        .done(done0), .table_valid(tv0), .table_out(to0), .pass(pass0)
    );

    trainer_truth_table_sequencer #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena1), .start(start1), .sel_in(sel1),
        .y_in(y1), .a_out(a1), .b_out(b1), .sel_out(selo1), .busy(busy1),
        .done(done1), .table_valid(tv1), .table_out(to1), .pass(pass1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ideal response of each gate, evaluated from boolean operators.
    function automatic logic [3:0] gate_table(input logic [2:0] sel);
        logic [3:0] t;
        logic       a, b;
        t = 4'b0000;
        for (int ab = 0; ab < 4; ab++) begin
            a = ab[1];
            b = ab[0];
            case (sel)
                3'd0:    t[ab] = a & b;
                3'd1:    t[ab] = a | b;
                3'd2:    t[ab] = ~(a & b);
                3'd3:    t[ab] = ~(a | b);
                3'd4:    t[ab] = a ^ b;
                3'd5:    t[ab] = ~(a ^ b);
                3'd6:    t[ab] = ~a;
                default: t[ab] = 1'b0;
            endcase
        end
        return t;
    endfunction

    // Advance past one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full run on dut0, with timing checks on every edge. When disturb is set,
    // start is pulsed and sel_in changes to 100 in the middle of the run.
    task automatic run0(input logic [2:0] sel, input logic [3:0] tbl, input bit disturb,
                        input logic [3:0] exp_table, input logic exp_pass);
        tbl0   = tbl;
        sel0   = sel;
        start0 = 1'b1;
        step();                                   // edge 0
        start0 = 1'b0;
        check("start_busy",  8'(busy0), 8'd1);
        check("start_ab",    8'({a0, b0}), 8'd0);
        check("start_sel",   8'(selo0), 8'(sel));
        check("start_valid", 8'(tv0), 8'd0);
        check("start_pass",  8'(pass0), 8'd0);
        for (int e = 1; e <= 4 * (S0 + 1); e++) begin
            if (disturb && e == 3) begin
                start0 = 1'b1;
                sel0   = 3'b100;
            end
            if (disturb && e == 4) start0 = 1'b0;
            step();
            if (e < 4 * (S0 + 1)) begin
                check("mid_done", 8'(done0), 8'd0);
                if (e % (S0 + 1) == 0) check("vector_ab", 8'({a0, b0}), 8'(e / (S0 + 1)));
            end
        end
        check("done_pulse", 8'(done0), 8'd1);
        check("done_valid", 8'(tv0), 8'd1);
        check("done_table", 8'(to0), 8'(exp_table));
        check("done_pass",  8'(pass0), 8'(exp_pass));
        check("done_busy",  8'(busy0), 8'd1);
        check("done_sel",   8'(selo0), 8'(sel));
        step();
        check("after_done",  8'(done0), 8'd0);
        check("after_busy",  8'(busy0), 8'd0);
        check("after_valid", 8'(tv0), 8'd1);
        check("after_table", 8'(to0), 8'(exp_table));
        check("after_pass",  8'(pass0), 8'(exp_pass));
        sel0 = sel;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_tbl [7];
        logic [2:0] rsel;
        logic [3:0] rtbl;
        logic       rpass;

        exp_tbl = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011};

        rst_n  = 1'b0;
        ena0   = 1'b1;  start0 = 1'b0;  sel0 = 3'b000;  tbl0 = 4'b0000;
        ena1   = 1'b1;  start1 = 1'b0;  sel1 = 3'b000;  tbl1 = 4'b0000;
        #2;
        check("rst_busy",  8'(busy0), 8'd0);
        check("rst_done",  8'(done0), 8'd0);
        check("rst_valid", 8'(tv0), 8'd0);
        check("rst_table", 8'(to0), 8'd0);
        check("rst_pass",  8'(pass0), 8'd0);
        check("rst_ab",    8'({a0, b0}), 8'd0);
        check("rst_sel",   8'(selo0), 8'd0);
        #10 rst_n = 1'b1;
        step();

        // AND run
        run0(3'b000, gate_table(3'b000), 1'b0, 4'b1000, 1'b1);

        // Sweep of all defined selects, then reserved 111
        for (int s = 0; s < 7; s++)
            run0(3'(s), gate_table(3'(s)), 1'b0, exp_tbl[s], 1'b1);
        run0(3'b111, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Faulty gates
        run0(3'b001, 4'b0000, 1'b0, 4'b0000, 1'b0);
        run0(3'b100, 4'b1111, 1'b0, 4'b1111, 1'b0);

        // Ignored start/sel during run
        run0(3'b000, gate_table(3'b000), 1'b1, 4'b1000, 1'b1);

        // Abort at edge 7 (NAND: bit0 captured at edge 5 is 1)
        tbl0   = gate_table(3'b010);
        sel0   = 3'b010;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int e = 1; e <= 7; e++) step();
        check("pre_abort_table", 8'(to0), 8'b0001);
        ena0 = 1'b0;
        step();                                   // edge 8
        check("abort_busy",  8'(busy0), 8'd0);
        check("abort_table", 8'(to0), 8'd0);
        check("abort_ab",    8'({a0, b0}), 8'd0);
        check("abort_valid", 8'(tv0), 8'd0);
        check("abort_sel",   8'(selo0), 8'b010);
        for (int e = 0; e < 20; e++) begin
            step();
            check("abort_no_done", 8'(done0), 8'd0);
        end
        ena0 = 1'b1;
        run0(3'b010, gate_table(3'b010), 1'b0, 4'b0111, 1'b1);

        // Reset in the middle of a run, half a cycle after edge 12
        tbl0   = gate_table(3'b110);
        sel0   = 3'b110;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int e = 1; e <= 12; e++) step();
        check("pre_rst_busy", 8'(busy0), 8'd1);
        #4 rst_n = 1'b0;
        #1;
        check("mrst_busy",  8'(busy0), 8'd0);
        check("mrst_table", 8'(to0), 8'd0);
        check("mrst_ab",    8'({a0, b0}), 8'd0);
        check("mrst_sel",   8'(selo0), 8'd0);
        check("mrst_valid", 8'(tv0), 8'd0);
        check("mrst_done",  8'(done0), 8'd0);
        check("mrst_pass",  8'(pass0), 8'd0);
        #2 rst_n = 1'b1;
        step();

        // SETTLE_CYCLES = 1 run on dut1: done after edge 8
        tbl1   = gate_table(3'b100);
        sel1   = 3'b100;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("s1_busy", 8'(busy1), 8'd1);
        for (int e = 1; e <= 4 * (S1 + 1); e++) begin
            step();
            check("s1_done_timing", 8'(done1), 8'(e == 4 * (S1 + 1)));
        end
        check("s1_table", 8'(to1), 8'b0110);
        check("s1_pass",  8'(pass1), 8'd1);
        check("s1_valid", 8'(tv1), 8'd1);
        step();
        check("s1_after_busy", 8'(busy1), 8'd0);
        check("s1_after_done", 8'(done1), 8'd0);

        // Randomized runs on dut0 against the reference model
        for (int i = 0; i < 20; i++) begin
            rsel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) rtbl = gate_table(rsel);
            else                           rtbl = 4'($urandom);
            rpass = (rtbl == gate_table(rsel)) && (rsel != 3'b111);
            run0(rsel, rtbl, 1'b0, rtbl, rpass);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
